apb_modport: RTL and testbench
==============================

# apb_modport

Self-contained APB subsystem: an APB master bridge driving two internal zero-wait-state APB memory slaves. It sits under the testbench's `apb_if` driver/monitor pair. A simple command interface (`transfer`, `read_write`, addresses, write data) is converted into APB SETUP/ACCESS phases. Read data is returned on `apb_read_data_out`.

## Interface
- `AW`, default 9: address width. Bit `AW-1` selects the slave; bits `AW-2:0` are the word index.
- `DW`, default 8: data width.
- `pclk`, input, 1: single clock. All state updates on its rising edge.
- `presetn`, input, 1: reset, synchronous and active-high (asserted = 1, sampled on `pclk` rising edge), despite the `n` suffix.
- `transfer`, input, 1: request a transfer. Sampled every cycle in IDLE and in ACCESS.
- `read_write`, input, 1: direction. 1 = read, 0 = write.
- `apb_write_paddr`, input, AW: write address.
- `apb_write_data`, input, DW: write data.
- `apb_read_paddr`, input, AW: read address.
- `apb_read_data_out`, output, DW: registered read result.

## Operation
- Master FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Transitions:
  - IDLE → SETUP when `transfer`=1, else stay in IDLE.
  - SETUP → ACCESS unconditionally.
  - ACCESS → SETUP if `transfer`=1 (back-to-back transfer), else → IDLE.
- Slaves are always ready: PREADY=1 in ACCESS, no wait states, no PSLVERR.
- Command capture:
  - On every edge entering SETUP, register `read_write`.
  - For a write, register `apb_write_paddr` and `apb_write_data`; for a read, register `apb_read_paddr`.
  - Held values drive PADDR/PWDATA/PWRITE through SETUP and ACCESS. Input changes during the transfer are ignored.
- Slave decode:
  - PADDR[AW-1]=0 → slave 0; PADDR[AW-1]=1 → slave 1.
  - Only the selected slave sees PSEL. The other slave's memory is never touched.
- Each slave holds 2^(AW-1) words of DW bits (256×8 at defaults), indexed by PADDR[AW-2:0].
- Write: the memory word is updated at the edge that ends ACCESS.
- Read:
  - The selected slave drives PRDATA combinationally during ACCESS.
  - The master registers PRDATA into `apb_read_data_out` at the edge that ends ACCESS.
  - `apb_read_data_out` holds its value until the next completed read. Writes do not change it.
- Reset (`presetn`=1 at a rising edge):
  - FSM goes to IDLE.
  - `apb_read_data_out`, all captured command registers and all memory words of both slaves clear to 0.
  - Reset has priority over any in-progress transfer. An interrupted write does not commit.
- No address wrap logic is needed: every AW-bit address maps to exactly one word.

## Timing
- `transfer` sampled 1 at edge E while IDLE → SETUP during cycle E..E+1, ACCESS during E+1..E+2.
- The write commits, or `apb_read_data_out` updates, at edge E+2. Single-transfer latency is 2 cycles.
- Back-to-back transfers (`transfer` held 1) run at 2 cycles per transfer (SETUP, ACCESS, SETUP, ...). There is no IDLE cycle between them.
- Read-after-write to the same address in consecutive transfers returns the new data: the write commits before the read's ACCESS phase.
- `transfer` is ignored during SETUP.

## Test plan
- Reset: hold `presetn`=1 for 2 cycles, then read addr 0x000 and addr 0x1FF → `apb_read_data_out`=0x00 both times; FSM in IDLE after reset.
- Single write/read, slave 0: write 0x5A to 0x010, then read 0x010 → 0x5A appears 2 cycles after the read's `transfer` is sampled.
- Slave isolation: write 0xA5 to 0x110 (slave 1), then read 0x010 → 0x5A unchanged; read 0x110 → 0xA5.
- Back-to-back: hold `transfer`=1 and alternate write/read to 0x0FF with data 0x3C → read returns 0x3C; each transfer takes exactly 2 cycles.
- Reset mid-transfer: assert `presetn` during the ACCESS phase of a write of 0x77 to 0x020 → a subsequent read of 0x020 returns 0x00; `apb_read_data_out`=0 immediately after reset.
- Hold behaviour: after reading 0xA5, perform writes only → `apb_read_data_out` stays 0xA5.

Source files
------------

// File: rtl/apb_modport.sv
// ---------------------------------------------------------------------------
// apb_modport
//
// Self-contained APB subsystem: a command-to-APB master bridge that drives two
// zero-wait-state APB memory slaves. The MSB of the address selects the slave,
// the remaining bits index a word inside it.
//
// Ports (top, apb_modport):
//   pclk               in   clock, all state updates on its rising edge
//   presetn            in   synchronous reset, active HIGH despite the name
//   transfer           in   request a transfer (sampled in IDLE and ACCESS)
//   read_write         in   1 = read, 0 = write
//   apb_write_paddr    in   [AW-1:0] write address
//   apb_write_data     in   [DW-1:0] write data
//   apb_read_paddr     in   [AW-1:0] read address
//   apb_read_data_out  out  [DW-1:0] registered result of the last read
//
// Sub-modules in this file:
//   apb_mem_slave  - 2^(AW-1) x DW memory behind a zero-wait APB slave port
//   apb_master     - IDLE/SETUP/ACCESS bridge with command capture
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// apb_mem_slave
//
// Always-ready APB memory. Writes commit at the edge that ends ACCESS; read
// data is driven combinationally while the slave is in ACCESS and is zero
// otherwise, so the parent can OR or mux slave outputs freely.
//
// Ports:
//   pclk, presetn      clock, synchronous active-high reset
//   psel, penable      APB phase qualifiers (psel already decoded per slave)
//   pwrite             1 = write transfer
//   paddr              [IW-1:0] word index
//   pwdata             [DW-1:0] write data
//   prdata             [DW-1:0] read data (valid in ACCESS of a read)
//   pready             constant 1, no wait states
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int IW = 8,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [IW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready
);

    localparam int DEPTH = 1 << IW;

    logic [DW-1:0] mem [DEPTH];
    logic          access;

    assign access = psel & penable;
    assign pready = 1'b1;

    // NOTE: the memory is cleared by reset because the subsystem must come up
    // with every word reading zero; this forces flops rather than a RAM macro.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (access && pwrite) begin
            mem[paddr] <= pwdata;
        end
    end

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            prdata = mem[paddr];
        end
    end

endmodule

// ---------------------------------------------------------------------------
// apb_master
//
// Converts the command interface into APB SETUP/ACCESS phases. The command is
// captured on every edge that enters SETUP and held through ACCESS, so input
// changes during a transfer have no effect. Read data is registered at the
// edge that ends ACCESS and held until the next completed read.
//
// Ports:
//   pclk, presetn      clock, synchronous active-high reset
//   transfer           request a transfer
//   read_write         1 = read, 0 = write
//   apb_write_paddr    [AW-1:0] address used for writes
//   apb_write_data     [DW-1:0] data used for writes
//   apb_read_paddr     [AW-1:0] address used for reads
//   pready             slave ready (ends ACCESS)
//   prdata             [DW-1:0] slave read data
//   psel, penable      APB phase outputs
//   pwrite             APB direction (1 = write)
//   paddr, pwdata      held APB address / write data
//   apb_read_data_out  [DW-1:0] registered read result
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    input  logic          pready,
    input  logic [DW-1:0] prdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    output logic [DW-1:0] apb_read_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic          pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic [DW-1:0] rdata_q;
    logic          enter_setup;
    logic          read_done;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        psel    = 1'b0;
        penable = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                // Slaves are always ready, but honour pready so a waited
                // slave would stretch ACCESS rather than drop the transfer.
                if (pready) begin
                    state_d = transfer ? SETUP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SETUP is only ever entered from IDLE or ACCESS, so a next state of
    // SETUP always marks a fresh command.
    assign enter_setup = (state_d == SETUP);
    assign read_done   = (state_q == ACCESS) && pready && !pwrite_q;

    always_ff @(posedge pclk) begin
        if (presetn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (enter_setup) begin
            pwrite_q <= ~read_write;
            if (read_write) begin
                paddr_q <= apb_read_paddr;
            end else begin
                paddr_q  <= apb_write_paddr;
                pwdata_q <= apb_write_data;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (presetn) begin
            rdata_q <= '0;
        end else if (read_done) begin
            rdata_q <= prdata;
        end
    end

    assign pwrite            = pwrite_q;
    assign paddr             = paddr_q;
    assign pwdata            = pwdata_q;
    assign apb_read_data_out = rdata_q;

endmodule

// ---------------------------------------------------------------------------
// apb_modport (top)
//
// Wires the master to two memory slaves. paddr[AW-1] picks the slave; only
// the selected slave sees psel, so the other one is never written.
// ---------------------------------------------------------------------------
module apb_modport #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out
);

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    logic          slave_sel;
    logic          psel0;
    logic          psel1;
    logic [DW-1:0] prdata0;
    logic [DW-1:0] prdata1;
    logic          pready0;
    logic          pready1;

    assign slave_sel = paddr[AW-1];
    assign psel0     = psel & ~slave_sel;
    assign psel1     = psel &  slave_sel;
    assign prdata    = slave_sel ? prdata1 : prdata0;
    assign pready    = slave_sel ? pready1 : pready0;

    apb_master #(
        .AW (AW),
        .DW (DW)
    ) u_master (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .pready            (pready),
        .prdata            (prdata),
        .psel              (psel),
        .penable           (penable),
        .pwrite            (pwrite),
        .paddr             (paddr),
        .pwdata            (pwdata),
        .apb_read_data_out (apb_read_data_out)
    );

    apb_mem_slave #(
        .IW (AW - 1),
        .DW (DW)
    ) u_slave0 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel0),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr[AW-2:0]),
        .pwdata  (pwdata),
        .prdata  (prdata0),
        .pready  (pready0)
    );

    apb_mem_slave #(
        .IW (AW - 1),
        .DW (DW)
    ) u_slave1 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr[AW-2:0]),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready1)
    );

endmodule

// File: tb/tb_apb_modport.sv
// ---------------------------------------------------------------------------
// tb_apb_modport
//
// Directed bench for apb_modport at default parameters (AW=9, DW=8).
// Inputs change 1 ns after each rising edge; outputs are checked there too,
// well away from the next active edge. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_apb_modport;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          pclk;
    logic          presetn;
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_read_data_out;

    int n_vec = 0;
    int n_err = 0;

    apb_modport #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One complete non-overlapping transfer. The command inputs are scrambled
    // after the SETUP edge so a bench pass also shows they were captured.
    task automatic xfer(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        transfer        = 1'b1;
        read_write      = rw;
        apb_write_paddr = addr;
        apb_read_paddr  = addr;
        apb_write_data  = data;
        tick();                         // E: now in SETUP
        transfer        = 1'b0;
        read_write      = ~rw;
        apb_write_paddr = ~addr;
        apb_read_paddr  = ~addr;
        apb_write_data  = ~data;
        tick();                         // E+1: ACCESS
        tick();                         // E+2: done, back in IDLE
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        xfer(1'b1, addr, 8'h00);
        check(tag, 32'(apb_read_data_out), 32'(exp));
    endtask

    initial begin
        presetn         = 1'b1;
        transfer        = 1'b0;
        read_write      = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_read_paddr  = '0;

        // ---- Reset held for two edges ----
        tick();
        tick();
        presetn = 1'b0;
        check("reset_rdata", 32'(apb_read_data_out), 32'h00);
        check("reset_psel", 32'(dut.psel), 32'h0);
        check("reset_penable", 32'(dut.penable), 32'h0);
        read_check("reset_rd_000", 9'h000, 8'h00);
        read_check("reset_rd_1ff", 9'h1FF, 8'h00);

        // ---- Single write/read on slave 0, with latency check ----
        xfer(1'b0, 9'h010, 8'h5A);
        check("wr_no_rdata_change", 32'(apb_read_data_out), 32'h00);
        transfer       = 1'b1;
        read_write     = 1'b1;
        apb_read_paddr = 9'h010;
        tick();                                   // E: SETUP
        check("rd_setup_psel", 32'(dut.psel), 32'h1);
        check("rd_setup_penable", 32'(dut.penable), 32'h0);
        transfer       = 1'b0;
        apb_read_paddr = 9'h110;                  // must be ignored
        tick();                                   // E+1: ACCESS
        check("rd_access_penable", 32'(dut.penable), 32'h1);
        check("rd_lat_e1", 32'(apb_read_data_out), 32'h00);
        tick();                                   // E+2: result registered
        check("rd_lat_e2", 32'(apb_read_data_out), 32'h5A);
        check("rd_idle_psel", 32'(dut.psel), 32'h0);

        // ---- Slave isolation ----
        read_check("iso_s1_before", 9'h110, 8'h00);
        xfer(1'b0, 9'h110, 8'hA5);
        read_check("iso_s0_kept", 9'h010, 8'h5A);
        read_check("iso_s1_rd", 9'h110, 8'hA5);

        // ---- Hold: writes only, output keeps 0xA5 ----
        xfer(1'b0, 9'h005, 8'h11);
        check("hold_after_wr0", 32'(apb_read_data_out), 32'hA5);
        xfer(1'b0, 9'h105, 8'h22);
        check("hold_after_wr1", 32'(apb_read_data_out), 32'hA5);
        read_check("hold_wr0_landed", 9'h005, 8'h11);
        read_check("hold_wr1_landed", 9'h105, 8'h22);
        read_check("hold_back_to_a5", 9'h110, 8'hA5);

        // ---- Back-to-back write then read of 0x0FF ----
        transfer        = 1'b1;
        read_write      = 1'b0;
        apb_write_paddr = 9'h0FF;
        apb_write_data  = 8'h3C;
        tick();                                   // SETUP (write)
        check("b2b_wr_setup", 32'({dut.psel, dut.penable}), 32'h2);
        read_write      = 1'b1;                   // ignored in SETUP
        apb_read_paddr  = 9'h0FF;
        apb_write_data  = 8'hC3;
        tick();                                   // ACCESS (write)
        check("b2b_wr_access", 32'({dut.psel, dut.penable}), 32'h3);
        tick();                                   // SETUP (read), no IDLE gap
        check("b2b_rd_setup", 32'({dut.psel, dut.penable}), 32'h2);
        check("b2b_rd_pwrite", 32'(dut.pwrite), 32'h0);
        transfer        = 1'b0;
        tick();                                   // ACCESS (read)
        check("b2b_rd_access", 32'({dut.psel, dut.penable}), 32'h3);
        check("b2b_rd_hold", 32'(apb_read_data_out), 32'hA5);
        tick();                                   // done
        check("b2b_rd_data", 32'(apb_read_data_out), 32'h3C);
        check("b2b_idle", 32'({dut.psel, dut.penable}), 32'h0);

        // ---- Reset during ACCESS of a write ----
        transfer        = 1'b1;
        read_write      = 1'b0;
        apb_write_paddr = 9'h020;
        apb_write_data  = 8'h77;
        tick();                                   // SETUP
        transfer        = 1'b0;
        tick();                                   // ACCESS
        check("rst_mid_access", 32'({dut.psel, dut.penable}), 32'h3);
        presetn = 1'b1;
        tick();                                   // reset wins this edge
        presetn = 1'b0;
        check("rst_mid_rdata", 32'(apb_read_data_out), 32'h00);
        check("rst_mid_idle", 32'({dut.psel, dut.penable}), 32'h0);
        read_check("rst_mid_no_commit", 9'h020, 8'h00);
        read_check("rst_clr_s0", 9'h0FF, 8'h00);
        read_check("rst_clr_s1", 9'h110, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
